// File: rtl/memory_dp_if.sv
// Request/response bundle for the dual-port RAM: port A read/write, port B read-only,
// plus the busy flag raised while the reset sweep runs.
interface memory_dp_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  a_en;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_rvalid;
    logic                  b_en;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_rvalid;
    logic                  busy;

    modport master (
        output a_en, a_we, a_addr, a_wdata, b_en, b_addr,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, busy
    );

    modport slave (
        input  a_en, a_we, a_addr, a_wdata, b_en, b_addr,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, busy
    );
endinterface

// File: rtl/memory_dp.sv
// Dual-port synchronous RAM: port A read/write, port B read-only, one shared array.
// After reset a sweep writes INIT_VALUE to every word before any request is accepted.
module memory_dp #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst,
    memory_dp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] a_old, b_old;
    logic                  a_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = bus.a_addr;
        mem_wdata  = bus.a_wdata;
        a_old      = mem[bus.a_addr];
        b_old      = mem[bus.b_addr];
        a_wr       = bus.a_en && bus.a_we;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = INIT_VALUE;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (bus.a_en) begin
                    a_rvalid_d = 1'b1;
                    mem_we     = bus.a_we;
                    a_rdata_d  = (bus.a_we && RDW_MODE == 0) ? bus.a_wdata : a_old;
                end
                if (bus.b_en) begin
                    b_rvalid_d = 1'b1;
                    // Write-first forwards port A's data to a colliding port B read.
                    b_rdata_d  = (a_wr && RDW_MODE == 0 && bus.a_addr == bus.b_addr)
                                 ? bus.a_wdata : b_old;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // The array has no reset; writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp: dut0 is write-first with INIT 8'hA5, dut1 is
// read-first with INIT 8'h00; both receive identical stimulus.
module tb_memory_dp;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    memory_dp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
    memory_dp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();

    memory_dp #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RDW_MODE(0), .INIT_VALUE(8'hA5))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    memory_dp #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RDW_MODE(1), .INIT_VALUE(8'h00))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic set_a(input logic en, input logic we, input logic [7:0] addr, input logic [7:0] data);
        if0.a_en = en; if0.a_we = we; if0.a_addr = addr; if0.a_wdata = data;
        if1.a_en = en; if1.a_we = we; if1.a_addr = addr; if1.a_wdata = data;
    endtask

    task automatic set_b(input logic en, input logic [7:0] addr);
        if0.b_en = en; if0.b_addr = addr;
        if1.b_en = en; if1.b_addr = addr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 8'h00);
        tick;
        tick;
        checks++;
        if ({if0.busy, if0.a_rvalid, if0.b_rvalid, if0.a_rdata, if0.b_rdata} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL reset_dut0: got busy=%b arv=%b brv=%b ard=%h brd=%h, want 1 0 0 00 00",
                     if0.busy, if0.a_rvalid, if0.b_rvalid, if0.a_rdata, if0.b_rdata);
        end
        checks++;
        if ({if1.busy, if1.a_rvalid, if1.b_rvalid, if1.a_rdata, if1.b_rdata} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL reset_dut1: got busy=%b arv=%b brv=%b ard=%h brd=%h, want 1 0 0 00 00",
                     if1.busy, if1.a_rvalid, if1.b_rvalid, if1.a_rdata, if1.b_rdata);
        end
    endtask

    task automatic test_busy_requests;
        int n;
        set_a(1'b1, 1'b1, 8'h05, 8'h77);
        set_b(1'b1, 8'h05);
        rst = 1'b0;
        n = 0;
        while (n < 1000) begin
            tick;
            n++;
            checks++;
            if ({if0.a_rvalid, if0.b_rvalid, if1.a_rvalid, if1.b_rvalid} !== 4'b0000) begin
                errors++;
                $display("FAIL busy_rvalid edge %0d: got %b%b%b%b, want 0000", n,
                         if0.a_rvalid, if0.b_rvalid, if1.a_rvalid, if1.b_rvalid);
            end
            if (if0.busy !== 1'b1) break;
        end
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 8'h00);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL sweep_edges: got %0d, want 256", n);
        end
        checks++;
        if (if1.busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_busy_dut1: got %b, want 0", if1.busy);
        end
    endtask

    task automatic test_sweep_contents;
        for (int i = 0; i < 256; i++) begin
            set_b(1'b1, 8'(i));
            tick;
            checks++;
            if (if0.b_rdata !== 8'hA5 || if0.b_rvalid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_dut0[%0d]: got %h/%b, want a5/1", i, if0.b_rdata, if0.b_rvalid);
            end
            checks++;
            if (if1.b_rdata !== 8'h00 || if1.b_rvalid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_dut1[%0d]: got %h/%b, want 00/1", i, if1.b_rdata, if1.b_rvalid);
            end
        end
        set_b(1'b0, 8'h00);
        set_a(1'b1, 1'b0, 8'h05, 8'h00);
        tick;
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (if0.a_rdata !== 8'hA5 || if1.a_rdata !== 8'h00) begin
            errors++;
            $display("FAIL busy_write_dropped: got %h/%h, want a5/00", if0.a_rdata, if1.a_rdata);
        end
        tick;
        checks++;
        if ({if0.a_rvalid, if0.b_rvalid, if1.a_rvalid, if1.b_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_rvalid: got %b%b%b%b, want 0000",
                     if0.a_rvalid, if0.b_rvalid, if1.a_rvalid, if1.b_rvalid);
        end
    endtask

    task automatic test_basic_rw;
        set_a(1'b1, 1'b1, 8'h10, 8'h3C);
        tick;
        checks++;
        if (if0.a_rvalid !== 1'b1 || if1.a_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_rvalid: got %b/%b, want 1/1", if0.a_rvalid, if1.a_rvalid);
        end
        set_a(1'b1, 1'b0, 8'h10, 8'h00);
        tick;
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (if0.a_rdata !== 8'h3C || if1.a_rdata !== 8'h3C || if0.a_rvalid !== 1'b1 || if1.a_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL basic_read: got %h/%h rv %b/%b, want 3c/3c rv 1/1",
                     if0.a_rdata, if1.a_rdata, if0.a_rvalid, if1.a_rvalid);
        end
        tick;
        checks++;
        if (if0.a_rvalid !== 1'b0 || if1.a_rvalid !== 1'b0 || if0.a_rdata !== 8'h3C || if1.a_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL rvalid_pulse_hold: got rv %b/%b rd %h/%h, want rv 0/0 rd 3c/3c",
                     if0.a_rvalid, if1.a_rvalid, if0.a_rdata, if1.a_rdata);
        end
    endtask

    task automatic test_rdw_same_port;
        set_a(1'b1, 1'b1, 8'h20, 8'h11);
        tick;
        set_a(1'b1, 1'b1, 8'h20, 8'h22);
        tick;
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (if0.a_rdata !== 8'h22) begin
            errors++;
            $display("FAIL rdw_same_wf: got %h, want 22", if0.a_rdata);
        end
        checks++;
        if (if1.a_rdata !== 8'h11) begin
            errors++;
            $display("FAIL rdw_same_rf: got %h, want 11", if1.a_rdata);
        end
    endtask

    task automatic test_cross_port;
        set_a(1'b1, 1'b1, 8'h40, 8'hFF);
        set_b(1'b1, 8'h40);
        tick;
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (if0.b_rdata !== 8'hFF || if0.b_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL cross_wf: got %h/%b, want ff/1", if0.b_rdata, if0.b_rvalid);
        end
        checks++;
        if (if1.b_rdata !== 8'h00 || if1.b_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL cross_rf: got %h/%b, want 00/1", if1.b_rdata, if1.b_rvalid);
        end
        tick;
        set_b(1'b0, 8'h00);
        checks++;
        if (if0.b_rdata !== 8'hFF || if1.b_rdata !== 8'hFF) begin
            errors++;
            $display("FAIL cross_after: got %h/%h, want ff/ff", if0.b_rdata, if1.b_rdata);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 1'b1, 8'h50 + 8'(i), 8'h60 + 8'(i));
            tick;
            checks++;
            if (if0.a_rvalid !== 1'b1 || if1.a_rvalid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_write_rv[%0d]: got %b/%b, want 1/1", i, if0.a_rvalid, if1.a_rvalid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 1'b0, 8'h50 + 8'(i), 8'h00);
            set_b(1'b1, 8'h53 - 8'(i));
            tick;
            checks++;
            if (if0.a_rdata !== 8'h60 + 8'(i) || if1.a_rdata !== 8'h60 + 8'(i) ||
                if0.a_rvalid !== 1'b1 || if1.a_rvalid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_a[%0d]: got %h/%h rv %b/%b, want %h", i,
                         if0.a_rdata, if1.a_rdata, if0.a_rvalid, if1.a_rvalid, 8'h60 + 8'(i));
            end
            checks++;
            if (if0.b_rdata !== 8'h63 - 8'(i) || if1.b_rdata !== 8'h63 - 8'(i) ||
                if0.b_rvalid !== 1'b1 || if1.b_rvalid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_b[%0d]: got %h/%h rv %b/%b, want %h", i,
                         if0.b_rdata, if1.b_rdata, if0.b_rvalid, if1.b_rvalid, 8'h63 - 8'(i));
            end
        end
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 8'h00);
    endtask

    task automatic test_mid_sweep;
        int n;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        repeat (100) tick;
        rst = 1'b1;
        #1;
        checks++;
        if ({if0.busy, if0.a_rvalid, if0.b_rvalid, if0.a_rdata, if0.b_rdata} !== {3'b100, 16'h0000} ||
            {if1.busy, if1.a_rvalid, if1.b_rvalid, if1.a_rdata, if1.b_rdata} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ard=%h/%h brd=%h/%h busy=%b/%b, want 00 00 busy 1",
                     if0.a_rdata, if1.a_rdata, if0.b_rdata, if1.b_rdata, if0.busy, if1.busy);
        end
        tick;
        rst = 1'b0;
        n = 0;
        while (n < 1000) begin
            tick;
            n++;
            if (if0.busy !== 1'b1) break;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL mid_sweep_edges: got %0d, want 256", n);
        end
        set_a(1'b1, 1'b0, 8'h10, 8'h00);
        tick;
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (if0.a_rdata !== 8'hA5 || if1.a_rdata !== 8'h00) begin
            errors++;
            $display("FAIL resweep_contents: got %h/%h, want a5/00", if0.a_rdata, if1.a_rdata);
        end
    endtask

    initial begin
        test_reset;
        test_busy_requests;
        test_sweep_contents;
        test_basic_rw;
        test_rdw_same_port;
        test_cross_port;
        test_back_to_back;
        test_mid_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
